// File: rtl/rnd_enable_stream_buffer.sv
// Elastic FIFO + output register whose advance is gated by a randomized enable; exposes stall statistics.
// Latency: 2 cycles minimum from push to out_valid, plus 1 per en_rnd=0 cycle that blocks an advance.
// Backpressure: in_ready drops when the FIFO holds DEPTH beats; out_valid/out_data hold while out_ready=0.
module rnd_enable_stream_buffer #(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 4,
   parameter int CNT_W       = 8,
   parameter int STALL_LIMIT = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_rnd,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              clr_stats,
   output logic [CNT_W-1:0]  stall_run,
   output logic [CNT_W-1:0]  stall_peak,
   output logic [CNT_W-1:0]  stall_total,
   output logic              starve_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STALL_LIMIT);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;

   logic push;
   logic pop;
   logic not_empty;
   logic slot_free;
   logic advance;
   logic stall;
   logic [CNT_W-1:0] run_inc;

   // A full FIFO refuses input even when a pop happens in the same cycle.
   assign in_ready  = (count != FULL_CNT);
   assign push      = in_valid & in_ready;
   assign not_empty = (count != '0);
   assign slot_free = ~out_valid | out_ready;
   assign advance   = en_rnd & not_empty & slot_free;
   assign pop       = advance;
   assign stall     = ~en_rnd & not_empty & slot_free;
   assign run_inc   = (stall_run == CNT_MAX) ? stall_run : stall_run + CNT_W'(1);
   assign starve_o  = (stall_run >= LIMIT);

   // Payload storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Output register: loads on an enabled advance, otherwise drains on handshake and holds data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (advance) begin
         out_valid <= 1'b1;
         out_data  <= mem[rd_ptr];
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Stall statistics: a stall is a cycle where only the missing enable blocked an advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_run   <= '0;
         stall_peak  <= '0;
         stall_total <= '0;
      end else if (clr_stats) begin
         stall_run   <= '0;
         stall_peak  <= '0;
         stall_total <= '0;
      end else if (stall) begin
         stall_run   <= run_inc;
         stall_total <= (stall_total == CNT_MAX) ? stall_total : stall_total + CNT_W'(1);
         if (run_inc > stall_peak) stall_peak <= run_inc;
      end else begin
         stall_run <= '0;
      end
   end

endmodule

// File: tb/tb_rnd_enable_stream_buffer.sv
// Testbench for rnd_enable_stream_buffer: table vectors, directed corner sequences, random traffic vs queue model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised through out_ready and a full FIFO.
module tb_rnd_enable_stream_buffer;

   localparam int DEPTH = 4;
   localparam int CMAX  = 255;
   localparam int LIM   = 6;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en_rnd;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       clr_stats;
   logic [7:0] stall_run;
   logic [7:0] stall_peak;
   logic [7:0] stall_total;
   logic       starve_o;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int         m_q[$];
   logic       m_ov;
   logic [7:0] m_od;
   int         m_run, m_peak, m_total;

   typedef struct {
      logic       iv;
      logic [7:0] id;
      logic       en;
      logic       ordy;
      logic       ov;
      logic [7:0] od;
      logic       ir;
   } vec_t;

   vec_t tbl[$];

   rnd_enable_stream_buffer #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(8), .STALL_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n), .en_rnd(en_rnd),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .clr_stats(clr_stats), .stall_run(stall_run), .stall_peak(stall_peak),
      .stall_total(stall_total), .starve_o(starve_o)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ov = 1'b0; m_od = 8'h00;
      m_run = 0; m_peak = 0; m_total = 0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_edge();
      bit push, slot, adv, stl;
      push = in_valid && (m_q.size() != DEPTH);
      slot = !m_ov || out_ready;
      adv  = en_rnd && (m_q.size() != 0) && slot;
      stl  = !en_rnd && (m_q.size() != 0) && slot;
      if (adv) begin
         m_od = 8'(m_q.pop_front());
         m_ov = 1'b1;
      end else if (m_ov && out_ready) begin
         m_ov = 1'b0;
      end
      if (push) m_q.push_back(int'(in_data));
      if (clr_stats) begin
         m_run = 0; m_peak = 0; m_total = 0;
      end else if (stl) begin
         m_run   = (m_run   < CMAX) ? m_run + 1   : CMAX;
         m_total = (m_total < CMAX) ? m_total + 1 : CMAX;
         if (m_run > m_peak) m_peak = m_run;
      end else begin
         m_run = 0;
      end
   endtask

   task automatic check_model();
      chk("out_valid",   32'(out_valid),   32'(m_ov));
      chk("out_data",    32'(out_data),    32'(m_od));
      chk("in_ready",    32'(in_ready),    32'(m_q.size() != DEPTH));
      chk("stall_run",   32'(stall_run),   32'(m_run));
      chk("stall_peak",  32'(stall_peak),  32'(m_peak));
      chk("stall_total", 32'(stall_total), 32'(m_total));
      chk("starve_o",    32'(starve_o),    32'(m_run >= LIM));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #2;
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic iv, input logic [7:0] id, input logic en, input logic ordy, input logic clr);
      in_valid = iv; in_data = id; en_rnd = en; out_ready = ordy; clr_stats = clr;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      model_reset();
      #12;
      // Reset state
      chk("rst out_valid",   32'(out_valid),   0);
      chk("rst out_data",    32'(out_data),    0);
      chk("rst in_ready",    32'(in_ready),    1);
      chk("rst stall_run",   32'(stall_run),   0);
      chk("rst stall_peak",  32'(stall_peak),  0);
      chk("rst stall_total", 32'(stall_total), 0);
      chk("rst starve_o",    32'(starve_o),    0);
      rst_n = 1'b1;

      // Back-to-back flow with en=1, then fill against backpressure and release.
      tbl.push_back('{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1});
      tbl.push_back('{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1});
      tbl.push_back('{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h33, 1'b1});
      tbl.push_back('{1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1});
      tbl.push_back('{1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b1});
      tbl.push_back('{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b1});
      tbl.push_back('{1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b1});
      tbl.push_back('{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0});
      tbl.push_back('{1'b1, 8'hA6, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1});
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].iv, tbl[i].id, tbl[i].en, tbl[i].ordy, 1'b0);
         step();
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
         chk($sformatf("vec%0d out_data", i),  32'(out_data),  32'(tbl[i].od));
         chk($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(tbl[i].ir));
      end
      chk("flow stall_total", 32'(stall_total), 0);

      // Stall run of 7 with one buffered beat
      do_reset();
      drive(1'b1, 8'h5C, 1'b0, 1'b1, 1'b0);
      step();
      for (int i = 1; i <= 7; i++) begin
         drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
         step();
         chk($sformatf("run%0d stall_run", i), 32'(stall_run), 32'(i));
         chk($sformatf("run%0d starve_o", i),  32'(starve_o),  32'(i >= LIM));
         chk($sformatf("run%0d out_valid", i), 32'(out_valid), 0);
      end
      chk("run stall_peak",  32'(stall_peak),  7);
      chk("run stall_total", 32'(stall_total), 7);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      step();
      chk("run emit valid", 32'(out_valid), 1);
      chk("run emit data",  32'(out_data),  32'h5C);
      chk("run cleared",    32'(stall_run), 0);
      chk("run starve off", 32'(starve_o),  0);

      // Empty FIFO with en=0 is not a stall
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
         step();
      end
      chk("empty stall_run",   32'(stall_run),   0);
      chk("empty stall_peak",  32'(stall_peak),  0);
      chk("empty stall_total", 32'(stall_total), 0);

      // clr_stats in the middle of a stall run
      drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
         step();
      end
      chk("pre-clr stall_run", 32'(stall_run), 3);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      step();
      chk("clr stall_run",   32'(stall_run),   0);
      chk("clr stall_peak",  32'(stall_peak),  0);
      chk("clr stall_total", 32'(stall_total), 0);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step();
      chk("post-clr stall_run",   32'(stall_run),   1);
      chk("post-clr stall_peak",  32'(stall_peak),  1);
      chk("post-clr stall_total", 32'(stall_total), 1);

      // Asynchronous reset with 3 beats buffered and out_valid=1
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
         step();
      end
      chk("pre-rst out_valid", 32'(out_valid), 1);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step();
      chk("pre-rst stall_run", 32'(stall_run), 1);
      rst_n = 1'b0;
      model_reset();
      #2;
      chk("async out_valid", 32'(out_valid), 0);
      chk("async in_ready",  32'(in_ready),  1);
      chk("async stall_run", 32'(stall_run), 0);
      chk("async out_data",  32'(out_data),  0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
         step();
         chk($sformatf("post-rst%0d no stale", i), 32'(out_valid), 0);
      end

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 9) < 6),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
